// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
// Contents:
//   state_e - controller state encoding (IDLE=0, SHIFT=1, DONE=2).
//             The unused code 2'd3 is recovered to IDLE by the top level.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell. Purely combinational; the sequencing and all
// state are owned by serial_adder_ctrl.
// Ports:
//   a, b, cin  in   1  operand bits and carry-in
//   sum        out  1  a ^ b ^ cin
//   cout       out  1  majority(a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder. Captures two operands and a carry-in on an
// accepted start, feeds full_adder one bit pair per clock (LSB first) with a
// registered carry between bits, then presents a registered sum/carry-out
// together with a one-cycle done pulse.
// Ports:
//   clk       in   1      clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request; only looked at in IDLE or DONE
//   a_in      in   WIDTH  operand A, captured on accept
//   b_in      in   WIDTH  operand B, captured on accept
//   cin_in    in   1      initial carry, captured on accept
//   busy      out  1      addition in progress
//   done      out  1      one-cycle result-valid pulse
//   sum_out   out  WIDTH  result, held until the next completion
//   cout_out  out  1      final carry, held with sum_out
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d, cout_q, cout_d;

  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] res_nxt;

  full_adder u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  // Result shift register with this cycle's sum bit entering at the MSB.
  // On the last bit it is the complete result, so sum_out loads it directly.
  generate
    if (WIDTH == 1) begin : g_res1
      assign res_nxt = fa_sum;
    end else begin : g_resn
      assign res_nxt = {fa_sum, res_sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        res_sr_d = res_nxt;
        carry_d  = fa_cout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_nxt;
          cout_d  = fa_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench: WIDTH=8 instance for timing/corner cases, WIDTH=2 instance
// for an exhaustive sweep against a + b + cin.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
    .cin_in(cin8), .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_in(a2), .b_in(b2),
    .cin_in(cin2), .busy(busy2), .done(done2), .sum_out(sum2), .cout_out(cout2)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start for one cycle, then wait (bounded) for done.
  // lat = edges after the accept edge until done is seen (expected WIDTH).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     output int lat);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic cin,
                     output int lat);
    @(negedge clk);
    a2 = a; b2 = b; cin2 = cin; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, ndone, bad_lat;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

    // Reset state
    #12;
    chk("reset_w8", {busy8, done8, cout8, sum8}, 32'h0);
    chk("reset_w2", {busy2, done2, cout2, sum2}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Timing: 5A + 3C, cycle by cycle
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("t1_e0_busy_done", {busy8, done8}, 2'b10);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t1_e%0d_busy_done", k), {busy8, done8}, 2'b10);
    end
    chk("t1_no_partial", {cout8, sum8}, 9'h000);
    @(negedge clk);
    chk("t1_e8_busy_done", {busy8, done8}, 2'b01);
    chk("t1_result", {cout8, sum8}, 9'h096);
    @(negedge clk);
    chk("t1_done_pulse_1cyc", {busy8, done8}, 2'b00);
    chk("t1_result_held", {cout8, sum8}, 9'h096);

    // Start while busy is ignored
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);                 // past E0
    start8 = 1'b0;
    @(negedge clk);                 // past E0+1
    @(negedge clk);                 // past E0+2
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);                 // past E0+3
    start8 = 1'b0;
    lat = 3;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t2_latency", lat, 8);
    chk("t2_result", {cout8, sum8}, 9'h096);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    chk("t2_single_done", ndone, 0);
    chk("t2_idle", busy8, 1'b0);

    // Back-to-back: start held through the DONE cycle
    op8(8'h5A, 8'h3C, 1'b0, lat);
    chk("t3_first_latency", lat, 8);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("t3_reaccept", {busy8, done8}, 2'b10);
    chk("t3_first_held", {cout8, sum8}, 9'h096);
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t3_second_latency", lat, 8);
    chk("t3_second_result", {cout8, sum8}, 9'h031);

    // Reset in the middle of an operation
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);                 // E0+4
    #1 rst_n = 1'b0;
    #1 chk("t4_reset_async", {busy8, done8, cout8, sum8}, 32'h0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    chk("t4_no_done", ndone, 0);
    chk("t4_outputs_zero", {busy8, cout8, sum8}, 32'h0);

    // Carry ripple and corners
    op8(8'hFF, 8'h01, 1'b0, lat);
    chk("t5_ff_01_lat", lat, 8);
    chk("t5_ff_01", {cout8, sum8}, 9'h100);
    op8(8'hFF, 8'hFF, 1'b1, lat);
    chk("t5_ff_ff_c1", {cout8, sum8}, 9'h1FF);
    op8(8'h00, 8'h00, 1'b1, lat);
    chk("t5_00_00_c1", {cout8, sum8}, 9'h001);
    op8(8'h80, 8'h80, 1'b0, lat);
    chk("t5_80_80", {cout8, sum8}, 9'h100);
    op8(8'hA5, 8'h5A, 1'b1, lat);
    chk("t5_a5_5a_c1", {cout8, sum8}, 9'h100);

    // Exhaustive WIDTH=2
    bad_lat = 0;
    for (int i = 0; i < 32; i++) begin
      logic [1:0] ea, eb;
      logic       ec;
      logic [2:0] exp3;
      ea = 2'(i >> 3);
      eb = 2'(i >> 1);
      ec = i[0];
      exp3 = 3'(ea) + 3'(eb) + 3'(ec);
      op2(ea, eb, ec, lat);
      if (lat != 2) bad_lat++;
      chk($sformatf("t6_w2_%0d_%0d_%0d", ea, eb, ec), {cout2, sum2}, exp3);
    end
    chk("t6_w2_latency", bad_lat, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
